// File: rtl/mips_mem_arbiter.sv
// Lets a Harvard MIPS core (fetch port + data port) share one unified single-port synchronous RAM.
// One transaction in flight; data wins ties unless fetches have lost STARVE_LIMIT times in a row.
module mips_mem_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_address,
    input  logic        instr_read,
    output logic [31:0] instr_readdata,
    output logic        instr_waitrequest,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        data_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    output logic        proto_err
);
    localparam int unsigned LAT_W    = $clog2(READ_LATENCY + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

    state_t              state;
    owner_t              owner;
    logic                is_read;
    logic                dropped;
    logic [LAT_W-1:0]    lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;

    logic data_req_c;
    logic starved_c;
    logic grant_instr_c;
    logic owner_req_c;

    // Fetch wins only when it is alone or has been starved long enough.
    assign data_req_c    = data_read | data_write;
    assign starved_c     = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
    assign grant_instr_c = instr_read & (~data_req_c | starved_c);
    assign owner_req_c   = (owner == OWN_INSTR) ? instr_read : data_req_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            owner             <= OWN_INSTR;
            is_read           <= 1'b0;
            dropped           <= 1'b0;
            lat_cnt           <= '0;
            starve_cnt        <= '0;
            mem_address       <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_writedata     <= '0;
            mem_byteenable    <= '0;
            instr_readdata    <= '0;
            data_readdata     <= '0;
            instr_waitrequest <= 1'b1;
            data_waitrequest  <= 1'b1;
            proto_err         <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            proto_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_read | data_req_c) begin
                        state   <= S_ISSUE;
                        dropped <= 1'b0;
                        if (grant_instr_c) begin
                            owner          <= OWN_INSTR;
                            is_read        <= 1'b1;
                            mem_read       <= 1'b1;
                            mem_address    <= instr_address;
                            mem_byteenable <= 4'b1111;
                            starve_cnt     <= '0;
                        end else begin
                            // A simultaneous read+write request is issued as a write.
                            owner          <= OWN_DATA;
                            is_read        <= ~data_write;
                            mem_read       <= ~data_write;
                            mem_write      <= data_write;
                            mem_address    <= data_address;
                            mem_byteenable <= data_byteenable;
                            if (data_write) begin
                                mem_writedata <= data_writedata;
                            end
                            proto_err <= data_read & data_write;
                            if (instr_read && !starved_c) begin
                                starve_cnt <= starve_cnt + STARVE_W'(1);
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT_W'(READ_LATENCY - 1);
                    if (is_read) begin
                        state   <= S_WAIT;
                        dropped <= ~owner_req_c;
                    end else begin
                        state     <= S_DONE;
                        proto_err <= ~owner_req_c;
                        if (owner == OWN_INSTR) instr_waitrequest <= 1'b0;
                        else                    data_waitrequest  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!owner_req_c) begin
                        dropped <= 1'b1;
                    end
                    if (lat_cnt == '0) begin
                        // Last wait cycle: memory data is valid now.
                        state     <= S_DONE;
                        proto_err <= dropped | ~owner_req_c;
                        if (owner == OWN_INSTR) begin
                            instr_readdata    <= mem_readdata;
                            instr_waitrequest <= 1'b0;
                        end else begin
                            data_readdata    <= mem_readdata;
                            data_waitrequest <= 1'b0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_DONE: begin
                    state             <= S_IDLE;
                    instr_waitrequest <= 1'b1;
                    data_waitrequest  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: cycle-exact directed scenarios plus randomized traffic checked
// against a transaction-level memory image and the data-first/starvation grant rule.
module tb_mips_mem_arbiter;
    localparam int RL = 3;
    localparam int SL = 4;
    localparam logic [31:0] POISON = 32'hDEAD_0BAD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Main DUT (READ_LATENCY=3)
    logic [31:0] instr_address, instr_readdata, data_address, data_writedata, data_readdata;
    logic        instr_read, instr_waitrequest, data_read, data_write, data_waitrequest;
    logic [3:0]  data_byteenable, mem_byteenable;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, proto_err;

    mips_mem_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .instr_address(instr_address), .instr_read(instr_read),
        .instr_readdata(instr_readdata), .instr_waitrequest(instr_waitrequest),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_byteenable(data_byteenable),
        .data_readdata(data_readdata), .data_waitrequest(data_waitrequest),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .proto_err(proto_err)
    );

    // Second DUT (READ_LATENCY=1) for the fetch-only scenario
    logic [31:0] f_instr_address, f_instr_readdata, f_data_address, f_data_writedata, f_data_readdata;
    logic        f_instr_read, f_instr_waitrequest, f_data_read, f_data_write, f_data_waitrequest;
    logic [3:0]  f_data_byteenable, f_mem_byteenable;
    logic [31:0] f_mem_address, f_mem_writedata, f_mem_readdata;
    logic        f_mem_read, f_mem_write, f_proto_err;

    mips_mem_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(SL)) dut_f (
        .clk(clk), .rst(rst),
        .instr_address(f_instr_address), .instr_read(f_instr_read),
        .instr_readdata(f_instr_readdata), .instr_waitrequest(f_instr_waitrequest),
        .data_address(f_data_address), .data_read(f_data_read), .data_write(f_data_write),
        .data_writedata(f_data_writedata), .data_byteenable(f_data_byteenable),
        .data_readdata(f_data_readdata), .data_waitrequest(f_data_waitrequest),
        .mem_address(f_mem_address), .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_writedata(f_mem_writedata), .mem_byteenable(f_mem_byteenable),
        .mem_readdata(f_mem_readdata), .proto_err(f_proto_err)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[17:2], ~a[17:2]} ^ 32'h1357_9BDF;
    endfunction

    // Memory responder for the main DUT: byte-lane writes, RL-cycle read pipeline
    logic [31:0]  mdat [256];
    logic [255:0] mvalid;
    logic [31:0]  rpipe [RL];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mvalid[a[9:2]] ? mdat[a[9:2]] : init_word(a);
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mvalid <= '0;
            for (int i = 0; i < RL; i++) rpipe[i] <= POISON;
        end else begin
            rpipe[0] <= mem_read ? mem_word(mem_address) : POISON;
            for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
            if (mem_write) begin
                mdat[mem_address[9:2]]   <= lane_merge(mem_word(mem_address), mem_writedata, mem_byteenable);
                mvalid[mem_address[9:2]] <= 1'b1;
            end
        end
    end
    assign mem_readdata = rpipe[RL-1];

    // Boot-ROM style responder for the fetch DUT
    logic [31:0] f_pipe;
    always @(posedge clk or posedge rst) begin
        if (rst) f_pipe <= POISON;
        else     f_pipe <= f_mem_read ? ((f_mem_address == 32'hBFC0_0000) ? 32'h2402_0005
                                                                          : init_word(f_mem_address)) : POISON;
    end
    assign f_mem_readdata = f_pipe;

    // Reference memory image, updated when stores complete
    logic [31:0]  ref_dat [256];
    logic [255:0] ref_valid;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_valid[a[9:2]] ? ref_dat[a[9:2]] : init_word(a);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        ref_dat[a[9:2]]   = (ref_read(a) & ~m) | (d & m);
        ref_valid[a[9:2]] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_address = '0; instr_read = 1'b0;
        data_address = '0; data_read = 1'b0; data_write = 1'b0;
        data_writedata = '0; data_byteenable = '0;
        f_instr_address = '0; f_instr_read = 1'b0;
        f_data_address = '0; f_data_read = 1'b0; f_data_write = 1'b0;
        f_data_writedata = '0; f_data_byteenable = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        ref_valid = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    // Requests start in the calling cycle (cycle 0); returns in the IDLE cycle after DONE.
    task automatic data_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, output int lat, output logic [31:0] rd,
                             output logic perr);
        data_read = ~wr; data_write = wr; data_address = addr;
        data_writedata = wd; data_byteenable = be;
        lat = -1; rd = '0; perr = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (!data_waitrequest) begin
                lat = c; rd = data_readdata; perr = proto_err;
                break;
            end
        end
        step();
        data_read = 1'b0; data_write = 1'b0;
    endtask

    task automatic instr_xfer(input logic [31:0] addr, output int lat, output logic [31:0] rd);
        instr_read = 1'b1; instr_address = addr;
        lat = -1; rd = '0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (!instr_waitrequest) begin
                lat = c; rd = instr_readdata;
                break;
            end
        end
        step();
        instr_read = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        ref_valid = '0;
        step(); step();
        vectors++;
        if ({mem_read, mem_write, mem_address, mem_writedata, mem_byteenable, instr_readdata,
             data_readdata, instr_waitrequest, data_waitrequest, proto_err} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state rd=%b wr=%b addr=%h wd=%h be=%h ird=%h drd=%h iwr=%b dwr=%b perr=%b, expected zeros with both waitrequest=1",
                     mem_read, mem_write, mem_address, mem_writedata, mem_byteenable, instr_readdata,
                     data_readdata, instr_waitrequest, data_waitrequest, proto_err);
        end
        vectors++;
        if ({f_mem_read, f_mem_write, f_instr_waitrequest, f_data_waitrequest, f_proto_err} !== 5'b00110) begin
            miscompares++;
            $display("FAIL reset_state_f got %b expected 00110",
                     {f_mem_read, f_mem_write, f_instr_waitrequest, f_data_waitrequest, f_proto_err});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        f_instr_address = 32'hBFC0_0000; f_instr_read = 1'b1;
        step();
        vectors++;
        if ({f_mem_read, f_mem_write, f_mem_byteenable, f_mem_address} !== {1'b1, 1'b0, 4'b1111, 32'hBFC0_0000}) begin
            miscompares++;
            $display("FAIL fetch_issue rd=%b wr=%b be=%b addr=%h expected rd=1 wr=0 be=1111 addr=bfc00000",
                     f_mem_read, f_mem_write, f_mem_byteenable, f_mem_address);
        end
        step();
        vectors++;
        if ({f_mem_read, f_instr_waitrequest} !== 2'b01) begin
            miscompares++;
            $display("FAIL fetch_wait rd=%b iwr=%b expected rd=0 iwr=1", f_mem_read, f_instr_waitrequest);
        end
        step();
        vectors++;
        if ({f_instr_waitrequest, f_data_waitrequest, f_instr_readdata} !== {1'b0, 1'b1, 32'h2402_0005}) begin
            miscompares++;
            $display("FAIL fetch_done iwr=%b dwr=%b data=%h expected iwr=0 dwr=1 data=24020005",
                     f_instr_waitrequest, f_data_waitrequest, f_instr_readdata);
        end
        step();
        f_instr_read = 1'b0;
        step();
    endtask

    task automatic test_store_load();
        int lat;
        logic [31:0] rd, exp;
        logic perr;
        data_write = 1'b1; data_address = 32'h0000_1000;
        data_writedata = 32'hDEAD_BEEF; data_byteenable = 4'b0011;
        step();
        vectors++;
        if ({mem_write, mem_read, mem_address, mem_writedata, mem_byteenable} !==
            {1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011}) begin
            miscompares++;
            $display("FAIL store_issue wr=%b rd=%b addr=%h wd=%h be=%b expected wr=1 rd=0 00001000 deadbeef 0011",
                     mem_write, mem_read, mem_address, mem_writedata, mem_byteenable);
        end
        step();
        vectors++;
        if ({mem_write, data_waitrequest, instr_waitrequest} !== 3'b001) begin
            miscompares++;
            $display("FAIL store_done wr=%b dwr=%b iwr=%b expected 0 0 1", mem_write, data_waitrequest, instr_waitrequest);
        end
        ref_write(32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
        step();
        data_write = 1'b0;
        exp = ref_read(32'h0000_1000);
        data_xfer(1'b0, 32'h0000_1000, '0, 4'hF, lat, rd, perr);
        vectors++;
        if (lat != RL + 2 || rd !== exp) begin
            miscompares++;
            $display("FAIL store_reload lat=%0d data=%h expected lat=%0d data=%h", lat, rd, RL + 2, exp);
        end
    endtask

    task automatic test_latency();
        int lat;
        logic [31:0] rd, fexp, dexp;
        logic perr;
        fexp = ref_read(32'h0000_0010);
        instr_xfer(32'h0000_0010, lat, rd);
        vectors++;
        if (lat != RL + 2 || rd !== fexp) begin
            miscompares++;
            $display("FAIL lat_fetch lat=%0d data=%h expected lat=%0d data=%h", lat, rd, RL + 2, fexp);
        end
        dexp = ref_read(32'h0000_0024);
        data_xfer(1'b0, 32'h0000_0024, '0, 4'hF, lat, rd, perr);
        vectors++;
        if (lat != RL + 2 || rd !== dexp || perr !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_load lat=%0d data=%h perr=%b expected lat=%0d data=%h perr=0", lat, rd, perr, RL + 2, dexp);
        end
        vectors++;
        if (instr_readdata !== fexp) begin
            miscompares++;
            $display("FAIL lat_instr_hold instr_readdata=%h expected %h", instr_readdata, fexp);
        end
        instr_xfer(32'h0000_0030, lat, rd);
        vectors++;
        if (data_readdata !== dexp) begin
            miscompares++;
            $display("FAIL lat_data_hold data_readdata=%h expected %h", data_readdata, dexp);
        end
    endtask

    task automatic test_proto();
        int lat;
        logic [31:0] rd, exp;
        logic perr;
        data_read = 1'b1; data_write = 1'b1; data_address = 32'h0000_0040;
        data_writedata = 32'hCAFE_F00D; data_byteenable = 4'hF;
        step();
        vectors++;
        if ({mem_write, mem_read, proto_err} !== 3'b101) begin
            miscompares++;
            $display("FAIL proto_rw_issue wr=%b rd=%b perr=%b expected 1 0 1", mem_write, mem_read, proto_err);
        end
        step();
        vectors++;
        if ({data_waitrequest, proto_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL proto_rw_done dwr=%b perr=%b expected 0 0", data_waitrequest, proto_err);
        end
        ref_write(32'h0000_0040, 32'hCAFE_F00D, 4'hF);
        step();
        data_read = 1'b0; data_write = 1'b0;
        exp = ref_read(32'h0000_0040);
        data_read = 1'b1;
        step();
        vectors++;
        if ({mem_read, proto_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL proto_drop_issue rd=%b perr=%b expected 1 0", mem_read, proto_err);
        end
        step();
        data_read = 1'b0;
        step(); step();
        vectors++;
        if ({data_waitrequest, proto_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL proto_drop_wait dwr=%b perr=%b expected 1 0", data_waitrequest, proto_err);
        end
        step();
        vectors++;
        if ({data_waitrequest, proto_err, data_readdata} !== {1'b0, 1'b1, exp}) begin
            miscompares++;
            $display("FAIL proto_drop_done dwr=%b perr=%b data=%h expected 0 1 %h", data_waitrequest, proto_err, data_readdata, exp);
        end
        step();
        vectors++;
        if ({data_waitrequest, proto_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL proto_drop_after dwr=%b perr=%b expected 1 0", data_waitrequest, proto_err);
        end
        data_xfer(1'b0, 32'h0000_0040, '0, 4'hF, lat, rd, perr);
        vectors++;
        if (lat != RL + 2 || rd !== exp || perr !== 1'b0) begin
            miscompares++;
            $display("FAIL proto_reload lat=%0d data=%h perr=%b expected lat=%0d data=%h perr=0", lat, rd, perr, RL + 2, exp);
        end
    endtask

    task automatic test_random_traffic();
        int lat, kind;
        logic [31:0] rd, a, wd, exp;
        logic [3:0] be;
        logic perr;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            a = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
            wd = $urandom;
            be = 4'($urandom);
            exp = ref_read(a);
            if (kind == 0) begin
                instr_xfer(a, lat, rd);
                vectors++;
                if (lat != RL + 2 || rd !== exp) begin
                    miscompares++;
                    $display("FAIL rand_fetch addr=%h lat=%0d data=%h expected lat=%0d data=%h", a, lat, rd, RL + 2, exp);
                end
            end else if (kind == 1) begin
                data_xfer(1'b0, a, '0, 4'hF, lat, rd, perr);
                vectors++;
                if (lat != RL + 2 || rd !== exp || perr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_load addr=%h lat=%0d data=%h perr=%b expected lat=%0d data=%h perr=0",
                             a, lat, rd, perr, RL + 2, exp);
                end
            end else begin
                data_xfer(1'b1, a, wd, be, lat, rd, perr);
                ref_write(a, wd, be);
                vectors++;
                if (lat != 2 || perr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_store addr=%h lat=%0d perr=%b expected lat=2 perr=0", a, lat, perr);
                end
            end
        end
    endtask

    // Both ports always requesting: every (SL+1)th grant must go to the fetch port.
    task automatic test_arbitration();
        int grants, prev_done, exp_cyc;
        logic [31:0] ia, da, dw;
        logic [3:0] dbe;
        logic dwr, upd_i, upd_d, exp_i;
        do_reset();
        grants = 0; prev_done = -1; upd_i = 1'b0; upd_d = 1'b0;
        ia = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
        da = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
        dwr = 1'($urandom_range(0, 1)); dw = $urandom; dbe = dwr ? 4'($urandom) : 4'hF;
        instr_read = 1'b1; instr_address = ia;
        data_read = ~dwr; data_write = dwr; data_address = da; data_writedata = dw; data_byteenable = dbe;
        for (int cyc = 1; cyc <= 300 && grants < 16; cyc++) begin
            step();
            if (upd_i) begin
                ia = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
                instr_address = ia; upd_i = 1'b0;
            end
            if (upd_d) begin
                da = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
                dwr = 1'($urandom_range(0, 1)); dw = $urandom; dbe = dwr ? 4'($urandom) : 4'hF;
                data_read = ~dwr; data_write = dwr; data_address = da; data_writedata = dw; data_byteenable = dbe;
                upd_d = 1'b0;
            end
            if (!instr_waitrequest || !data_waitrequest) begin
                exp_i = ((grants + 1) % (SL + 1) == 0);
                vectors++;
                if (!instr_waitrequest && !data_waitrequest) begin
                    miscompares++;
                    $display("FAIL arb_both_done grant=%0d both waitrequests low", grants);
                end else if ((!instr_waitrequest) !== exp_i) begin
                    miscompares++;
                    $display("FAIL arb_order grant=%0d owner=%s expected %s", grants,
                             !instr_waitrequest ? "I" : "D", exp_i ? "I" : "D");
                end
                if (!instr_waitrequest) begin
                    exp_cyc = prev_done + 1 + RL + 2;
                    vectors++;
                    if (instr_readdata !== ref_read(ia) || cyc != exp_cyc) begin
                        miscompares++;
                        $display("FAIL arb_fetch grant=%0d data=%h cycle=%0d expected data=%h cycle=%0d",
                                 grants, instr_readdata, cyc, ref_read(ia), exp_cyc);
                    end
                    upd_i = 1'b1;
                end else begin
                    exp_cyc = prev_done + 1 + (dwr ? 2 : RL + 2);
                    vectors++;
                    if ((!dwr && data_readdata !== ref_read(da)) || cyc != exp_cyc) begin
                        miscompares++;
                        $display("FAIL arb_data grant=%0d wr=%b data=%h cycle=%0d expected data=%h cycle=%0d",
                                 grants, dwr, data_readdata, cyc, ref_read(da), exp_cyc);
                    end
                    if (dwr) ref_write(da, dw, dbe);
                    upd_d = 1'b1;
                end
                prev_done = cyc;
                grants++;
            end
        end
        vectors++;
        if (grants < 16) begin
            miscompares++;
            $display("FAIL arb_timeout grants=%0d expected 16 within 300 cycles", grants);
        end
        instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_mid_reset();
        int lat;
        logic [31:0] rd;
        logic perr;
        data_read = 1'b1; data_address = 32'h0000_0008; data_byteenable = 4'hF;
        step();
        vectors++;
        if (mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_issue mem_read=%b expected 1", mem_read);
        end
        step(); step();
        rst = 1'b1;
        ref_valid = '0;
        #1;
        vectors++;
        if ({mem_read, mem_write, instr_waitrequest, data_waitrequest, proto_err} !== 5'b00110) begin
            miscompares++;
            $display("FAIL midrst_wait got %b expected 00110",
                     {mem_read, mem_write, instr_waitrequest, data_waitrequest, proto_err});
        end
        step();
        rst = 1'b0; data_read = 1'b0;
        step();
        instr_read = 1'b1; instr_address = 32'h0000_0004;
        step();
        rst = 1'b1;
        #1;
        vectors++;
        if ({mem_read, instr_waitrequest} !== 2'b01) begin
            miscompares++;
            $display("FAIL midrst_issue_async mem_read=%b iwr=%b expected 0 1", mem_read, instr_waitrequest);
        end
        step();
        rst = 1'b0; instr_read = 1'b0;
        step();
        data_xfer(1'b1, 32'h0000_000C, 32'h1234_5678, 4'hF, lat, rd, perr);
        ref_write(32'h0000_000C, 32'h1234_5678, 4'hF);
        vectors++;
        if (lat != 2 || perr !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_recover lat=%0d perr=%b expected lat=2 perr=0", lat, perr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch();
        test_store_load();
        test_proto();
        test_random_traffic();
        test_latency();
        test_arbitration();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
